instruction_fetch_loadable: RTL and testbench

Parametrised instruction-fetch stage with a runtime-loadable instruction memory, replacing the fixed-program fetch front end of the MIPS pipeline. The debug unit streams a program into the internal memory through a load port. The stage then fetches sequentially, honouring stall and jump/branch redirects from later stages. It stops cleanly on a HALT word. It feeds the IF/ID register and reports its state to the debug unit.

---
 rtl/instruction_fetch_loadable_if.sv | 38 +++
 rtl/instruction_fetch_loadable.sv | 135 +++++++++++++
 tb/tb_instruction_fetch_loadable.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_loadable_if.sv
// Bus between the debug/hazard side and the loadable instruction-fetch stage.
// master: drives redirect, stall and load-port requests, observes fetch state.
// slave : the fetch stage itself.
interface instruction_fetch_loadable_if #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              i_stall;
  logic              i_jump;
  logic [SIZE-1:0]   i_jump_addr;
  logic              i_load_start;
  logic              i_load_valid;
  logic [SIZE-1:0]   i_load_data;
  logic              i_load_done;
  logic [SIZE-1:0]   o_instruction;
  logic [SIZE-1:0]   o_pc;
  logic [SIZE-1:0]   o_pc_plus1;
  logic [1:0]        o_state;
  logic [ADDR_W:0]   o_load_count;
  logic              o_load_full;
  logic              o_halted;

  modport master (
    output i_stall, i_jump, i_jump_addr,
    output i_load_start, i_load_valid, i_load_data, i_load_done,
    input  o_instruction, o_pc, o_pc_plus1, o_state,
    input  o_load_count, o_load_full, o_halted
  );

  modport slave (
    input  i_stall, i_jump, i_jump_addr,
    input  i_load_start, i_load_valid, i_load_data, i_load_done,
    output o_instruction, o_pc, o_pc_plus1, o_state,
    output o_load_count, o_load_full, o_halted
  );
endinterface

// File: rtl/instruction_fetch_loadable.sv
// Instruction-fetch stage with a runtime-loadable instruction memory.
// The debug unit streams a program in through the load port (LOAD), then the
// stage fetches sequentially (RUN) honouring stall and jump redirects.
// Optional feature macro IF_HALT_DETECT_EN: when defined, fetching HALT_WORD
// parks the stage in HALTED; when undefined HALT_WORD is an ordinary word.
// Memory contents are never cleared; power-up contents rely on the target's
// zero-initialised storage (all NOPs).
module instruction_fetch_loadable #(
  parameter int unsigned     SIZE      = 32,
  parameter int unsigned     DEPTH     = 64,
  parameter logic [SIZE-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input logic                   clk,
  input logic                   rst,
  instruction_fetch_loadable_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [SIZE-1:0] DEPTH_PC  = SIZE'(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_LOAD   = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [SIZE-1:0] pc_q, pc_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            we;
  logic [SIZE-1:0] rd_word;
  logic [SIZE-1:0] pc_plus1;
  logic            halt_hit;

  logic [SIZE-1:0] mem_q [DEPTH];

  // Any next PC at or beyond the memory depth folds back to word 0.
  function automatic logic [SIZE-1:0] wrap_pc(input logic [SIZE-1:0] p);
    return (p >= DEPTH_PC) ? '0 : p;
  endfunction

  assign rd_word  = mem_q[pc_q[ADDR_W-1:0]];
  assign pc_plus1 = pc_q + SIZE'(1);

`ifdef IF_HALT_DETECT_EN
  assign halt_hit = (rd_word == HALT_WORD);
`else
  logic unused_halt_word;
  assign unused_halt_word = ^HALT_WORD;
  assign halt_hit = 1'b0;
`endif

  // Next-state, next-PC and load-pointer selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.i_load_start) begin
          state_d = ST_LOAD;
          pc_d    = '0;
          cnt_d   = '0;
        end else if (bus.i_stall) begin
          pc_d = pc_q;
        end else if (bus.i_jump) begin
          pc_d = wrap_pc(bus.i_jump_addr);
        end else if (halt_hit) begin
          state_d = ST_HALTED;
        end else begin
          pc_d = wrap_pc(pc_plus1);
        end
      end
      ST_LOAD: begin
        pc_d = '0;
        if (bus.i_load_start) begin
          cnt_d = '0;
        end else begin
          // A write and a done in the same cycle both take effect.
          if (bus.i_load_valid && (cnt_q != DEPTH_CNT)) begin
            we    = 1'b1;
            cnt_d = cnt_q + (ADDR_W+1)'(1);
          end
          if (bus.i_load_done) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_HALTED: begin
        if (bus.i_load_start) begin
          state_d = ST_LOAD;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
        pc_d    = '0;
      end
    endcase
  end

  // State, PC and load-pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem_q[cnt_q[ADDR_W-1:0]] <= bus.i_load_data;
    end
  end

  assign bus.o_instruction = (state_q == ST_RUN) ? rd_word : '0;
  assign bus.o_pc          = pc_q;
  assign bus.o_pc_plus1    = pc_plus1;
  assign bus.o_state       = state_q;
  assign bus.o_load_count  = cnt_q;
  assign bus.o_load_full   = (cnt_q == DEPTH_CNT);
`ifdef IF_HALT_DETECT_EN
  assign bus.o_halted      = (state_q == ST_HALTED);
`else
  assign bus.o_halted      = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_fetch_loadable.sv
// Bench for instruction_fetch_loadable (DEPTH=8): directed scenarios with
// literal expectations plus a randomized phase, all checked every cycle
// against a behavioural model of the fetch stage.
module tb_instruction_fetch_loadable;
  localparam int unsigned D    = 8;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
`ifdef IF_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic chk_en;
  int   vectors;
  int   miscompares;

  instruction_fetch_loadable_if #(.SIZE(32), .DEPTH(D)) bus ();

  instruction_fetch_loadable #(
    .SIZE(32), .DEPTH(D), .HALT_WORD(HALT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: 0 RUN, 1 LOAD, 2 HALTED.
  int          m_state;
  logic [31:0] m_pc;
  int          m_cnt;
  logic [31:0] m_mem [D];

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_pc = 0; m_cnt = 0;
    end else if (m_state == 0) begin
      if (bus.i_load_start) begin
        m_state = 1; m_pc = 0; m_cnt = 0;
      end else if (bus.i_stall) begin
        m_pc = m_pc;
      end else if (bus.i_jump) begin
        m_pc = (bus.i_jump_addr < D) ? bus.i_jump_addr : 32'd0;
      end else if (HALT_EN && m_mem[m_pc] == HALT) begin
        m_state = 2;
      end else begin
        m_pc = (m_pc + 1) % D;
      end
    end else if (m_state == 1) begin
      m_pc = 0;
      if (bus.i_load_start) begin
        m_cnt = 0;
      end else begin
        if (bus.i_load_valid && m_cnt < D) begin
          m_mem[m_cnt] = bus.i_load_data;
          m_cnt = m_cnt + 1;
        end
        if (bus.i_load_done) m_state = 0;
      end
    end else begin
      if (bus.i_load_start) begin
        m_state = 1; m_pc = 0; m_cnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("instr", bus.o_instruction, (m_state == 0) ? m_mem[m_pc] : 32'd0);
      check("pc", bus.o_pc, m_pc);
      check("pc_plus1", bus.o_pc_plus1, m_pc + 32'd1);
      check("state", 32'(bus.o_state), 32'(m_state));
      check("load_count", 32'(bus.o_load_count), 32'(m_cnt));
      check("load_full", 32'(bus.o_load_full), 32'(m_cnt == D));
      check("halted", 32'(bus.o_halted), 32'(m_state == 2));
    end
  end

  task automatic idle();
    bus.i_stall = 0; bus.i_jump = 0; bus.i_jump_addr = 0;
    bus.i_load_start = 0; bus.i_load_valid = 0; bus.i_load_data = 0;
    bus.i_load_done = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input int n, input logic [31:0] base, input bit halt_at4);
    bus.i_load_start = 1; step(); bus.i_load_start = 0;
    for (int i = 0; i < n; i++) begin
      bus.i_load_valid = 1;
      bus.i_load_data  = (halt_at4 && i == 4) ? HALT : base + 32'(i);
      step();
    end
    bus.i_load_valid = 0;
  endtask

  initial begin
    clk = 0; rst = 1; chk_en = 0; vectors = 0; miscompares = 0;
    for (int i = 0; i < int'(D); i++) m_mem[i] = 32'd0;
    idle();
    step(); step();
    rst = 0; chk_en = 1;
    check("rst_state", 32'(bus.o_state), 32'd0);
    check("rst_pc", bus.o_pc, 32'd0);
    check("rst_count", 32'(bus.o_load_count), 32'd0);
    check("rst_full", 32'(bus.o_load_full), 32'd0);
    check("rst_halted", 32'(bus.o_halted), 32'd0);
    check("rst_instr", bus.o_instruction, 32'd0);

    // Load three words then run.
    load_words(3, 32'hA000_0000, 1'b0);
    bus.i_load_done = 1; step(); bus.i_load_done = 0;
    check("abc_count", 32'(bus.o_load_count), 32'd3);
    check("abc_pc0", bus.o_pc, 32'd0);
    check("abc_instrA", bus.o_instruction, 32'hA000_0000);
    step();
    check("abc_pc1", bus.o_pc, 32'd1);
    check("abc_instrB", bus.o_instruction, 32'hA000_0001);
    step();
    check("abc_pc2", bus.o_pc, 32'd2);
    check("abc_instrC", bus.o_instruction, 32'hA000_0002);

    // Overflow: ten writes into eight words.
    load_words(10, 32'h0000_0100, 1'b0);
    check("ovf_full", 32'(bus.o_load_full), 32'd1);
    check("ovf_count", 32'(bus.o_load_count), 32'd8);
    check("ovf_load_instr", bus.o_instruction, 32'd0);
    bus.i_load_done = 1; step(); bus.i_load_done = 0;
    for (int i = 0; i < 8; i++) begin
      check("ovf_run_pc", bus.o_pc, 32'(i));
      check("ovf_run_instr", bus.o_instruction, 32'h100 + 32'(i));
      step();
    end
    check("ovf_wrap_pc", bus.o_pc, 32'd0);
    check("ovf_wrap_instr", bus.o_instruction, 32'h100);

    // Stall and jump.
    step(); step(); step();
    check("sj_pc3", bus.o_pc, 32'd3);
    bus.i_stall = 1; step();
    check("sj_stall1", bus.o_pc, 32'd3);
    step();
    check("sj_stall2", bus.o_pc, 32'd3);
    bus.i_stall = 0; bus.i_jump = 1; bus.i_jump_addr = 6; step();
    check("sj_jump6", bus.o_pc, 32'd6);
    bus.i_jump_addr = 9; step();
    check("sj_jump9", bus.o_pc, 32'd0);
    bus.i_jump = 0;

    // Halt word at index 4.
    load_words(8, 32'h0000_0200, 1'b1);
    bus.i_load_done = 1; step(); bus.i_load_done = 0;
    step(); step(); step(); step();
    check("halt_pc4", bus.o_pc, 32'd4);
    check("halt_word", bus.o_instruction, HALT);
    bus.i_stall = 1; step(); bus.i_stall = 0;
    check("halt_stall_pc", bus.o_pc, 32'd4);
    check("halt_stall_state", 32'(bus.o_state), 32'd0);
    step();
`ifdef IF_HALT_DETECT_EN
    check("halt_halted", 32'(bus.o_halted), 32'd1);
    check("halt_state", 32'(bus.o_state), 32'd2);
    check("halt_pc_held", bus.o_pc, 32'd4);
    check("halt_instr0", bus.o_instruction, 32'd0);
    bus.i_jump = 1; bus.i_jump_addr = 1; bus.i_stall = 1; step();
    bus.i_jump = 0; bus.i_stall = 0;
    check("halt_ignore_pc", bus.o_pc, 32'd4);
    check("halt_ignore_halted", 32'(bus.o_halted), 32'd1);
`else
    check("nohalt_halted", 32'(bus.o_halted), 32'd0);
    check("nohalt_pc5", bus.o_pc, 32'd5);
    check("nohalt_instr", bus.o_instruction, 32'h205);
`endif
    // Jump at the halt word redirects instead of halting.
    bus.i_load_start = 1; step(); bus.i_load_start = 0;
    bus.i_load_done = 1; step(); bus.i_load_done = 0;
    check("jh_count0", 32'(bus.o_load_count), 32'd0);
    step(); step(); step(); step();
    check("jh_at_halt", bus.o_instruction, HALT);
    bus.i_jump = 1; bus.i_jump_addr = 2; step(); bus.i_jump = 0;
    check("jh_pc2", bus.o_pc, 32'd2);
    check("jh_not_halted", 32'(bus.o_halted), 32'd0);
    check("jh_instr", bus.o_instruction, 32'h202);

    // Reset in the middle of a load.
    load_words(2, 32'h0000_0300, 1'b0);
    rst = 1; step(); rst = 0;
    check("rml_state", 32'(bus.o_state), 32'd0);
    check("rml_pc", bus.o_pc, 32'd0);
    check("rml_count", 32'(bus.o_load_count), 32'd0);
    check("rml_instr", bus.o_instruction, 32'h300);

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 32) == 0) begin
        bus.i_load_start = 1;
      end else begin
        bus.i_load_valid = ($urandom_range(0, 1) == 1) && !rst;
        bus.i_load_data  = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
        bus.i_load_done  = ($urandom_range(0, 19) == 0);
      end
      bus.i_stall     = ($urandom_range(0, 6) == 0);
      bus.i_jump      = ($urandom_range(0, 6) == 0);
      bus.i_jump_addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 11));
      step();
    end
    rst = 0;
    idle();
    step();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
